// File: rtl/cpu_sequencer.sv
// Control sequencer for the accumulator CPU: fetch/decode/execute FSM with memory wait states,
// JMP/NOP/HALT, illegal-opcode trap. Optional wait timeout is enabled by defining MEM_TIMEOUT_EN.
module cpu_sequencer #(
  parameter int WORD_W  = 8,
  parameter int OP_W    = 3,
  parameter int ADDR_W  = WORD_W - OP_W,
  parameter int TIMEOUT = 15
) (
  input  logic            clock,
  input  logic            n_reset,
  input  logic [OP_W-1:0] op,
  input  logic            z_flag,
  input  logic            mem_ready,
  output logic            load_MAR,
  output logic            load_MDR,
  output logic            load_IR,
  output logic            load_PC,
  output logic            load_ACC,
  output logic            PC_bus,
  output logic            ACC_bus,
  output logic            MDR_bus,
  output logic            Addr_bus,
  output logic            INC_PC,
  output logic            ALU_sub,
  output logic            ALU_pass,
  output logic            CS,
  output logic            R_NW,
  output logic            instr_done,
  output logic            halted,
  output logic            err
);

  typedef enum logic [3:0] {
    S_FETCH_ADDR  = 4'd0,
    S_FETCH_MEM   = 4'd1,
    S_FETCH_IR    = 4'd2,
    S_DECODE      = 4'd3,
    S_EXEC_ADDR   = 4'd4,
    S_EXEC_STORE  = 4'd5,
    S_EXEC_MEM    = 4'd6,
    S_EXEC_WB     = 4'd7,
    S_BRANCH      = 4'd8,
    S_HALTED      = 4'd9
  } state_e;

  if (OP_W < 3 || ADDR_W < 1 || TIMEOUT < 1) begin : g_param_chk
    $error("cpu_sequencer: OP_W must be >= 3, ADDR_W and TIMEOUT >= 1");
  end

  state_e state_q, state_d;
  logic   wr_q, wr_d;
  logic   pass_q, pass_d;
  logic   sub_q, sub_d;
  logic   err_q, err_d;
  logic   done_q;
  logic   op_hi_s;
  logic   tmo_s;

  // Opcode bits above the 3-bit base field make the instruction illegal.
  if (OP_W > 3) begin : g_op_hi
    assign op_hi_s = |op[OP_W-1:3];
  end else begin : g_op_no_hi
    assign op_hi_s = 1'b0;
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_C = CNT_W'(TIMEOUT);
  logic [CNT_W-1:0] cnt_q;

  // Wait counter: cleared outside MEM states, counts cycles without mem_ready.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      cnt_q <= '0;
    end else if ((state_q == S_FETCH_MEM || state_q == S_EXEC_MEM) && !mem_ready) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else begin
      cnt_q <= '0;
    end
  end

  assign tmo_s = (cnt_q == TO_C);
`else
  assign tmo_s = 1'b0;
`endif

  // State and decoded-instruction registers.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= S_FETCH_ADDR;
      wr_q    <= 1'b0;
      pass_q  <= 1'b0;
      sub_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      pass_q  <= pass_d;
      sub_q   <= sub_d;
      err_q   <= err_d;
      done_q  <= (state_d == S_FETCH_ADDR);
    end
  end

  // Next-state logic; op and z_flag matter only in DECODE.
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    pass_d  = pass_q;
    sub_d   = sub_q;
    err_d   = err_q;
    case (state_q)
      S_FETCH_ADDR: state_d = S_FETCH_MEM;
      S_FETCH_MEM: begin
        if (mem_ready) begin
          state_d = S_FETCH_IR;
        end else if (tmo_s) begin
          state_d = S_HALTED;
          err_d   = 1'b1;
        end else begin
          state_d = S_FETCH_MEM;
        end
      end
      S_FETCH_IR: state_d = S_DECODE;
      S_DECODE: begin
        if (op_hi_s) begin
          state_d = S_HALTED;
          err_d   = 1'b1;
        end else begin
          case (op[2:0])
            3'd0: begin state_d = S_EXEC_ADDR; wr_d = 1'b0; pass_d = 1'b1; sub_d = 1'b0; end
            3'd1: begin state_d = S_EXEC_ADDR; wr_d = 1'b1; pass_d = 1'b0; sub_d = 1'b0; end
            3'd2: begin state_d = S_EXEC_ADDR; wr_d = 1'b0; pass_d = 1'b0; sub_d = 1'b0; end
            3'd3: begin state_d = S_EXEC_ADDR; wr_d = 1'b0; pass_d = 1'b0; sub_d = 1'b1; end
            3'd4: state_d = z_flag ? S_FETCH_ADDR : S_BRANCH;
            3'd5: state_d = S_BRANCH;
            3'd6: state_d = S_FETCH_ADDR;
            3'd7: state_d = S_HALTED;
            default: begin
              state_d = S_HALTED;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      S_EXEC_ADDR:  state_d = wr_q ? S_EXEC_STORE : S_EXEC_MEM;
      S_EXEC_STORE: state_d = S_EXEC_MEM;
      S_EXEC_MEM: begin
        if (mem_ready) begin
          state_d = wr_q ? S_FETCH_ADDR : S_EXEC_WB;
        end else if (tmo_s) begin
          state_d = S_HALTED;
          err_d   = 1'b1;
        end else begin
          state_d = S_EXEC_MEM;
        end
      end
      S_EXEC_WB: state_d = S_FETCH_ADDR;
      S_BRANCH:  state_d = S_FETCH_ADDR;
      S_HALTED:  state_d = S_HALTED;
      default:   state_d = S_FETCH_ADDR;
    endcase
  end

  // Moore output decode; reset forces everything low without waiting for a clock.
  always_comb begin
    load_MAR = 1'b0;
    load_MDR = 1'b0;
    load_IR  = 1'b0;
    load_PC  = 1'b0;
    load_ACC = 1'b0;
    PC_bus   = 1'b0;
    ACC_bus  = 1'b0;
    MDR_bus  = 1'b0;
    Addr_bus = 1'b0;
    INC_PC   = 1'b0;
    ALU_sub  = 1'b0;
    ALU_pass = 1'b0;
    CS       = 1'b0;
    R_NW     = 1'b0;
    halted   = 1'b0;
    if (!n_reset) begin
      halted = 1'b0;
    end else begin
      case (state_q)
        S_FETCH_ADDR: begin PC_bus = 1'b1; load_MAR = 1'b1; end
        S_FETCH_MEM:  begin CS = 1'b1; R_NW = 1'b1; load_MDR = 1'b1; end
        S_FETCH_IR:   begin MDR_bus = 1'b1; load_IR = 1'b1; INC_PC = 1'b1; end
        S_DECODE:     halted = 1'b0;
        S_EXEC_ADDR:  begin Addr_bus = 1'b1; load_MAR = 1'b1; end
        S_EXEC_STORE: begin ACC_bus = 1'b1; load_MDR = 1'b1; end
        S_EXEC_MEM: begin
          CS       = 1'b1;
          R_NW     = !wr_q;
          load_MDR = !wr_q;
        end
        S_EXEC_WB: begin
          MDR_bus  = 1'b1;
          load_ACC = 1'b1;
          ALU_pass = pass_q;
          ALU_sub  = sub_q;
        end
        S_BRANCH:     begin Addr_bus = 1'b1; load_PC = 1'b1; end
        S_HALTED:     halted = 1'b1;
        default:      halted = 1'b0;
      endcase
    end
  end

  assign instr_done = done_q;
  assign err        = err_q;

endmodule
